// File: rtl/pat_search_engine.sv
// pat_search_engine: START/DONE accelerator that counts 5-bit pattern matches
// in a 32-byte message held in data memory and writes three result bytes back.
//   DST_BASE+0 : matches fully inside a byte
//   DST_BASE+1 : bytes holding at least one in-byte match
//   DST_BASE+2 : matches anywhere in the MSB-first bit stream (byte crossings included)
// Optional feature macro PAT_SEARCH_PERF_EN: adds a cycle counter written to
// DST_BASE+3 by an extra WR3 state (DONE latency grows from 37 to 38 cycles).
// Handshake: START is sampled on the rising clock edge; it is accepted only in
// IDLE or FIN, otherwise ignored. DONE is a level that rises once all result
// bytes are written and drops on the edge that accepts the next START.
module pat_search_engine #(
    parameter logic [7:0] SRC_BASE  = 8'd128,
    parameter logic [7:0] PAT_ADDR  = 8'd160,
    parameter logic [7:0] DST_BASE  = 8'd192,
    parameter int         NUM_BYTES = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    output logic       DONE,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_PAT = 3'd1,
        SCAN     = 3'd2,
        WR0      = 3'd3,
        WR1      = 3'd4,
        WR2      = 3'd5,
`ifdef PAT_SEARCH_PERF_EN
        WR3      = 3'd6,
`endif
        FIN      = 3'd7
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [4:0] pat;
    logic [7:0] prev;
    logic [4:0] idx;
    logic [7:0] ctb;
    logic [7:0] cto;
    logic [7:0] cts;
    logic       done_q;
`ifdef PAT_SEARCH_PERF_EN
    logic [7:0] cyc;
`endif

    logic       start_accept;
    logic [15:0] stream;
    logic [3:0] in_hits;
    logic [3:0] x_hits;
    logic [2:0] m;
    logic [2:0] x;

    assign start_accept = START && (state == IDLE || state == FIN);
    assign DONE         = done_q;

    // Window compares over the previous byte followed by the current byte
    always_comb begin
        stream  = {prev, mem_rd_data};
        in_hits = {stream[7:3] == pat, stream[6:2] == pat,
                   stream[5:1] == pat, stream[4:0] == pat};
        x_hits  = {stream[11:7] == pat, stream[10:6] == pat,
                   stream[9:5] == pat, stream[8:4] == pat};
        m = 3'(in_hits[0]) + 3'(in_hits[1]) + 3'(in_hits[2]) + 3'(in_hits[3]);
        // The first byte has no predecessor, so it contributes no crossing windows
        if (idx == 5'd0) begin
            x = 3'd0;
        end else begin
            x = 3'(x_hits[0]) + 3'(x_hits[1]) + 3'(x_hits[2]) + 3'(x_hits[3]);
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (START) state_next = LOAD_PAT;
            LOAD_PAT: state_next = SCAN;
            SCAN:     if (idx == LAST_IDX) state_next = WR0;
            WR0:      state_next = WR1;
            WR1:      state_next = WR2;
`ifdef PAT_SEARCH_PERF_EN
            WR2:      state_next = WR3;
            WR3:      state_next = FIN;
`else
            WR2:      state_next = FIN;
`endif
            FIN:      if (START) state_next = LOAD_PAT;
            default:  state_next = IDLE;
        endcase
    end

    // Memory port outputs decoded from the current state
    always_comb begin
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (state)
            LOAD_PAT: mem_addr = PAT_ADDR;
            SCAN:     mem_addr = SRC_BASE + {3'd0, idx};
            WR0: begin
                mem_addr    = DST_BASE;
                mem_wr_en   = 1'b1;
                mem_wr_data = ctb;
            end
            WR1: begin
                mem_addr    = DST_BASE + 8'd1;
                mem_wr_en   = 1'b1;
                mem_wr_data = cto;
            end
            WR2: begin
                mem_addr    = DST_BASE + 8'd2;
                mem_wr_en   = 1'b1;
                mem_wr_data = cts;
            end
`ifdef PAT_SEARCH_PERF_EN
            WR3: begin
                mem_addr    = DST_BASE + 8'd3;
                mem_wr_en   = 1'b1;
                mem_wr_data = cyc;
            end
`endif
            default: begin
                mem_addr    = 8'd0;
                mem_wr_en   = 1'b0;
                mem_wr_data = 8'd0;
            end
        endcase
    end

    // Pattern latch, scan index, previous byte and the three match counters
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pat  <= 5'd0;
            prev <= 8'd0;
            idx  <= 5'd0;
            ctb  <= 8'd0;
            cto  <= 8'd0;
            cts  <= 8'd0;
        end else if (start_accept) begin
            pat  <= 5'd0;
            prev <= 8'd0;
            idx  <= 5'd0;
            ctb  <= 8'd0;
            cto  <= 8'd0;
            cts  <= 8'd0;
        end else if (state == LOAD_PAT) begin
            pat <= mem_rd_data[7:3];
        end else if (state == SCAN) begin
            ctb  <= ctb + {5'd0, m};
            cto  <= cto + {7'd0, (m != 3'd0)};
            cts  <= cts + {5'd0, m} + {5'd0, x};
            prev <= mem_rd_data;
            idx  <= idx + 5'd1;
        end
    end

    // DONE level: set once FIN is reached, cleared by the accepted START
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            done_q <= 1'b0;
        end else if (start_accept) begin
            done_q <= 1'b0;
        end else if (state == FIN) begin
            done_q <= 1'b1;
        end
    end

`ifdef PAT_SEARCH_PERF_EN
    // Cycle counter: zeroed at the accepted START, counts through WR2
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cyc <= 8'd0;
        end else if (start_accept) begin
            cyc <= 8'd0;
        end else if (state == LOAD_PAT || state == SCAN || state == WR0 ||
                     state == WR1 || state == WR2) begin
            cyc <= cyc + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pat_search_engine.sv
// Testbench for pat_search_engine: memory model, directed vectors, randomized
// messages against a bit-stream reference model, reset abort and restart.
module tb_pat_search_engine;

`ifdef PAT_SEARCH_PERF_EN
    localparam int EXP_LAT = 38;
    localparam int EXP_NWR = 4;
`else
    localparam int EXP_LAT = 37;
    localparam int EXP_NWR = 3;
`endif
    localparam int TIMEOUT = 120;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic       DONE;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [0:255];
    logic [7:0] wlog_addr [0:1023];
    logic [7:0] wlog_data [0:1023];
    int         wr_count;

    int n_checks;
    int n_fail;

    pat_search_engine dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .DONE        (DONE),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    // Clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Combinational read port of the data memory
    assign mem_rd_data = mem[mem_addr];

    // Write monitor: logs every write strobe in order
    initial wr_count = 0;
    always @(posedge CLK) begin
        if (mem_wr_en === 1'b1) begin
            wlog_addr[wr_count] <= mem_addr;
            wlog_data[wr_count] <= mem_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    // Load the pattern byte and the 32 message bytes
    task automatic load_msg(input logic [4:0] p, input logic [7:0] msg [32]);
        mem[160] = {p, 3'($urandom_range(0, 7))};
        for (int k = 0; k < 32; k++) mem[128 + k] = msg[k];
    endtask

    // Reference model: slide a 5-bit window across the 256-bit MSB-first stream
    task automatic model(output int e_tb, output int e_to, output int e_ts);
        logic       bits [256];
        logic       hit_byte [32];
        logic [4:0] w;
        logic [4:0] p;
        p = mem[160][7:3];
        e_tb = 0;
        e_to = 0;
        e_ts = 0;
        for (int b = 0; b < 256; b++) bits[b] = mem[128 + b / 8][7 - (b % 8)];
        for (int k = 0; k < 32; k++) hit_byte[k] = 1'b0;
        for (int pos = 0; pos <= 251; pos++) begin
            w = {bits[pos], bits[pos + 1], bits[pos + 2], bits[pos + 3], bits[pos + 4]};
            if (w == p) begin
                e_ts++;
                if ((pos % 8) <= 3) begin
                    e_tb++;
                    hit_byte[pos / 8] = 1'b1;
                end
            end
        end
        for (int k = 0; k < 32; k++) if (hit_byte[k]) e_to++;
    endtask

    // Driver + checks for one complete operation
    task automatic run_op(input string name, input bit noise, input bit chk_drop);
        int base, lat, nwr, e_tb, e_to, e_ts;
        logic [7:0] exp_d [4];
        model(e_tb, e_to, e_ts);
        exp_d[0] = 8'(e_tb);
        exp_d[1] = 8'(e_to);
        exp_d[2] = 8'(e_ts);
        exp_d[3] = 8'd36;
        base = wr_count;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        if (chk_drop) begin
            n_checks++;
            if (DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_drop: DONE=%b required 0", name, DONE);
            end
        end
        lat = 0;
        while (lat < TIMEOUT && DONE !== 1'b1) begin
            if (noise && lat >= 3 && lat <= 25) START = 1'($urandom_range(0, 1));
            else START = 1'b0;
            @(posedge CLK);
            #1;
            lat++;
        end
        START = 1'b0;
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles required %0d", name, lat, EXP_LAT);
        end
        nwr = wr_count - base;
        n_checks++;
        if (nwr !== EXP_NWR) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d required %0d", name, nwr, EXP_NWR);
        end
        for (int k = 0; k < EXP_NWR; k++) begin
            if (k < nwr) begin
                n_checks++;
                if (wlog_addr[base + k] !== 8'(192 + k)) begin
                    n_fail++;
                    $display("FAIL %s wr%0d_addr: got %0d required %0d", name, k,
                             wlog_addr[base + k], 192 + k);
                end
                n_checks++;
                if (wlog_data[base + k] !== exp_d[k]) begin
                    n_fail++;
                    $display("FAIL %s wr%0d_data: got %0d required %0d", name, k,
                             wlog_data[base + k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", DONE); end
        n_checks++;
        if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b required 0", mem_wr_en); end
        n_checks++;
        if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d required 0", mem_addr); end
        n_checks++;
        if (mem_wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_wr_data: got %0d required 0", mem_wr_data); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_vectors();
        logic [7:0] msg [32];
        for (int k = 0; k < 32; k++) msg[k] = 8'h00;
        load_msg(5'b00000, msg);
        run_op("zero_pat_zero_msg", 1'b0, 1'b0);
        load_msg(5'b11111, msg);
        run_op("ones_pat_zero_msg", 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) msg[k] = 8'h55;
        load_msg(5'b10101, msg);
        run_op("alt_pat_55", 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) msg[k] = (k == 0) ? 8'h00 : 8'hFF;
        load_msg(5'b00000, msg);
        run_op("byte0_only", 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) msg[k] = 8'h00;
        msg[5] = 8'h07;
        msg[6] = 8'hC0;
        load_msg(5'b11111, msg);
        run_op("crossing", 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) msg[k] = 8'h00;
        msg[30] = 8'h01;
        msg[31] = 8'hF0;
        load_msg(5'b11111, msg);
        run_op("crossing_last", 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] msg [32];
        logic [4:0] p;
        for (int r = 0; r < 8; r++) begin
            p = 5'($urandom_range(0, 31));
            for (int k = 0; k < 32; k++) begin
                case ($urandom_range(0, 3))
                    0: msg[k] = 8'($urandom);
                    1: msg[k] = {p, 3'($urandom)};
                    2: msg[k] = {3'($urandom), p};
                    default: msg[k] = r[0] ? 8'hFF : 8'h00;
                endcase
            end
            load_msg(p, msg);
            run_op("random", 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] msg [32];
        int base;
        for (int k = 0; k < 32; k++) msg[k] = 8'($urandom);
        load_msg(5'($urandom_range(0, 31)), msg);
        base = wr_count;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (11) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        n_checks++;
        if (DONE !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b required 0", DONE); end
        n_checks++;
        if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_wr_en: got %b required 0", mem_wr_en); end
        n_checks++;
        if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL abort_addr: got %0d required 0", mem_addr); end
        @(negedge CLK);
        RESET = 1'b0;
        repeat (50) @(posedge CLK);
        #1;
        n_checks++;
        if (wr_count !== base) begin
            n_fail++;
            $display("FAIL abort_no_writes: got %0d writes required 0", wr_count - base);
        end
        n_checks++;
        if (DONE !== 1'b0) begin n_fail++; $display("FAIL abort_idle_done: got %b required 0", DONE); end
        run_op("after_abort_noisy_start", 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [32];
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 32; k++) msg[k] = 8'($urandom);
            load_msg(5'($urandom_range(0, 31)), msg);
            run_op("back_to_back", 1'b0, 1'b1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RESET    = 1'b1;
        START    = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'hA5;
        test_reset();
        test_vectors();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
